// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI burst controller.
package spi_pkg;

  localparam int unsigned SPI_DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned CS_SETUP_DEF   = 2;
  localparam int unsigned CS_HOLD_DEF    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIssue,
    StWaitDone,
    StHold
  } spi_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy counter; Depth must be a power of two.
module spi_sync_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DepthC = (AW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == DepthC);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + (AW + 1)'(1);
      end else if (pop_ok && !push_ok) begin
        cnt_q <= cnt_q - (AW + 1)'(1);
      end
    end
  end

  // Storage needs no reset: the counter alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer between byte FIFOs and a byte-wide SPI master; frames each
// burst with chip select and keeps at most one transfer in flight.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CS_SETUP   = CS_SETUP_DEF,
  parameter int unsigned CS_HOLD    = CS_HOLD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SPI_DATA_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  input  logic                  tx_last_i,
  output logic                  tx_ready_o,
  output logic [SPI_DATA_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  rx_last_o,
  input  logic                  rx_ready_i,
  output logic [SPI_DATA_W-1:0] spi_din_o,
  output logic                  spi_start_o,
  input  logic                  spi_ready_i,
  input  logic [SPI_DATA_W-1:0] spi_dout_i,
  input  logic                  spi_done_tick_i,
  output logic                  cs_n_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = 8;
  // The ISSUE decision cycle closes the setup window and the accepting
  // WAIT_DONE cycle opens the hold window, so each dwell is one shorter.
  localparam logic [CntW-1:0] SetupLast = CntW'((CS_SETUP > 1) ? CS_SETUP - 2 : 0);
  localparam logic [CntW-1:0] HoldLast  = CntW'((CS_HOLD > 1) ? CS_HOLD - 2 : 0);

  spi_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  cs_n_q, start_q, last_q, rdy_q;
  logic [SPI_DATA_W-1:0] din_q;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [SPI_DATA_W:0]   tx_rdata, rx_rdata;
  logic                  issue, rx_push;

  assign issue   = (state_q == StIssue) && !tx_empty && spi_ready_i && !rx_full;
  assign rx_push = (state_q == StWaitDone) && spi_done_tick_i;

  assign tx_ready_o  = rdy_q && !tx_full;
  assign rx_valid_o  = !rx_empty;
  assign rx_data_o   = rx_rdata[SPI_DATA_W-1:0];
  assign rx_last_o   = rx_rdata[SPI_DATA_W];
  assign spi_din_o   = din_q;
  assign spi_start_o = start_q;
  assign cs_n_o      = cs_n_q;
  assign busy_o      = (state_q != StIdle);

  spi_sync_fifo #(
    .Width (SPI_DATA_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i && tx_ready_o),
    .wdata_i ({tx_last_i, tx_data_i}),
    .pop_i   (issue),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  spi_sync_fifo #(
    .Width (SPI_DATA_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .wdata_i ({last_q, spi_dout_i}),
    .pop_i   (rx_valid_o && rx_ready_i),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      din_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!tx_empty) begin
            cs_n_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= (CS_SETUP > 1) ? StSetup : StIssue;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) state_q <= StIssue;
          else                    cnt_q   <= cnt_q + CntW'(1);
        end
        StIssue: begin
          if (issue) begin
            start_q <= 1'b1;
            din_q   <= tx_rdata[SPI_DATA_W-1:0];
            last_q  <= tx_rdata[SPI_DATA_W];
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (spi_done_tick_i) begin
            if (!last_q) begin
              state_q <= StIssue;
            end else if (CS_HOLD > 1) begin
              cnt_q   <= '0;
              state_q <= StHold;
            end else begin
              cs_n_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cs_n_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a behavioural SPI master and event monitors.
module tb_spi_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_last;
  logic       rx_ready = 1'b1;
  logic [7:0] spi_din;
  logic       spi_start;
  logic       spi_ready;
  logic [7:0] spi_dout;
  logic       spi_done;
  logic       cs_n, busy;

  logic       force_tick = 1'b0;
  logic       m_hold = 1'b0;
  logic       echo_fix = 1'b0;
  logic [7:0] echo_val = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_burst_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_last_i       (tx_last),
    .tx_ready_o      (tx_ready),
    .rx_data_o       (rx_data),
    .rx_valid_o      (rx_valid),
    .rx_last_o       (rx_last),
    .rx_ready_i      (rx_ready),
    .spi_din_o       (spi_din),
    .spi_start_o     (spi_start),
    .spi_ready_i     (spi_ready),
    .spi_dout_i      (spi_dout),
    .spi_done_tick_i (spi_done),
    .cs_n_o          (cs_n),
    .busy_o          (busy)
  );

  // SPI master model: fixed latency, loopback unless echo_fix is set.
  logic       m_busy = 1'b0;
  logic [2:0] m_cnt = 3'd0;
  logic [7:0] m_byte = 8'h00;
  logic       done_r = 1'b0;
  logic [7:0] dout_r = 8'h00;

  assign spi_ready = !m_busy && !m_hold;
  assign spi_done  = done_r || force_tick;
  assign spi_dout  = dout_r;

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 3'd0) begin
        m_busy <= 1'b0;
        done_r <= 1'b1;
        dout_r <= echo_fix ? echo_val : m_byte;
      end else begin
        m_cnt <= m_cnt - 3'd1;
      end
    end else if (spi_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 3'd3;
      m_byte <= spi_din;
    end
  end

  // Event monitor: cycle stamps, counters and the RX pop log.
  int         cyc = 0;
  logic       cs_prev = 1'b1;
  int         n_fall = 0, n_rise = 0, n_start = 0, rx_n = 0;
  int         fall_cyc = 0, rise_cyc = 0, start_cyc = 0, done_cyc = 0;
  logic [7:0] start_din = 8'h00;
  logic [8:0] rx_log [64];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_prev <= cs_n;
    if (cs_prev && !cs_n) begin
      n_fall   <= n_fall + 1;
      fall_cyc <= cyc;
    end
    if (!cs_prev && cs_n) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (spi_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
      start_din <= spi_din;
    end
    if (spi_done) done_cyc <= cyc;
    if (rx_valid && rx_ready) begin
      rx_log[rx_n[5:0]] <= {rx_last, rx_data};
      rx_n <= rx_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag, input int idx, input logic [7:0] d, input logic l);
    check_eq(tag, 32'(rx_log[idx]), 32'({l, d}));
  endtask

  task automatic push(input string tag, input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " push accepted"}, 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int base_rise);
    int n = 0;
    while (n_rise == base_rise && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " frame end"}, 32'(n_rise != base_rise), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  int b_start, b_fall, b_rise, b_rx;

  task automatic take_base();
    b_start = n_start;
    b_fall  = n_fall;
    b_rise  = n_rise;
    b_rx    = rx_n;
  endtask

  task automatic single_byte(input string tag);
    take_base();
    echo_fix = 1'b1;
    echo_val = 8'h3C;
    push(tag, 8'hA5, 1'b1);
    wait_frame(tag, b_rise);
    check_eq({tag, " starts"}, n_start - b_start, 32'd1);
    check_eq({tag, " setup gap"}, start_cyc - fall_cyc, 32'd2);
    check_eq({tag, " din"}, 32'(start_din), 32'h0000_00A5);
    check_eq({tag, " hold gap"}, rise_cyc - done_cyc, 32'd2);
    check_eq({tag, " rx count"}, rx_n - b_rx, 32'd1);
    check_rx({tag, " rx0"}, b_rx, 8'h3C, 1'b1);
    check_eq({tag, " idle busy"}, 32'(busy), 32'd0);
    echo_fix = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst cs_n", 32'(cs_n), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst start", 32'(spi_start), 32'd0);
    check_eq("rst din", 32'(spi_din), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("post-rst tx_ready", 32'(tx_ready), 32'd1);

    // Single byte with fixed echo
    single_byte("t1");

    // Three-byte loopback burst
    take_base();
    push("t2", 8'h01, 1'b0);
    push("t2", 8'h02, 1'b0);
    push("t2", 8'h03, 1'b1);
    wait_frame("t2", b_rise);
    check_eq("t2 starts", n_start - b_start, 32'd3);
    check_eq("t2 cs frames", n_fall - b_fall, 32'd1);
    check_eq("t2 rx count", rx_n - b_rx, 32'd3);
    check_rx("t2 rx0", b_rx, 8'h01, 1'b0);
    check_rx("t2 rx1", b_rx + 1, 8'h02, 1'b0);
    check_rx("t2 rx2", b_rx + 2, 8'h03, 1'b1);

    // RX back-pressure: depth-4 RX stalls issue after four transfers
    take_base();
    rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push("t3", 8'h31 + 8'(i), i == 5);
    repeat (60) @(negedge clk);
    check_eq("t3 stalled starts", n_start - b_start, 32'd4);
    check_eq("t3 stalled busy", 32'(busy), 32'd1);
    check_eq("t3 stalled cs_n", 32'(cs_n), 32'd0);
    check_eq("t3 stalled rx_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_frame("t3", b_rise);
    check_eq("t3 starts", n_start - b_start, 32'd6);
    check_eq("t3 rx count", rx_n - b_rx, 32'd6);
    for (int i = 0; i < 6; i++) begin
      check_rx($sformatf("t3 rx%0d", i), b_rx + i, 8'h31 + 8'(i), i == 5);
    end

    // TX underrun mid-burst holds chip select
    take_base();
    push("t4", 8'h41, 1'b0);
    push("t4", 8'h42, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("t4 gap cs_n", 32'(cs_n), 32'd0);
    check_eq("t4 gap busy", 32'(busy), 32'd1);
    check_eq("t4 gap starts", n_start - b_start, 32'd2);
    push("t4", 8'h55, 1'b1);
    wait_frame("t4", b_rise);
    check_eq("t4 starts", n_start - b_start, 32'd3);
    check_eq("t4 cs frames", n_fall - b_fall, 32'd1);
    check_rx("t4 rx2", b_rx + 2, 8'h55, 1'b1);

    // Full TX FIFO ignores tx_valid
    take_base();
    m_hold = 1'b1;
    for (int i = 0; i < 4; i++) push("t5", 8'h10 + 8'(i), i == 3);
    @(negedge clk);
    check_eq("t5 full tx_ready", 32'(tx_ready), 32'd0);
    check_eq("t5 held starts", n_start - b_start, 32'd0);
    tx_data  = 8'hEE;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    m_hold = 1'b0;
    wait_frame("t5", b_rise);
    repeat (5) @(negedge clk);
    check_eq("t5 starts", n_start - b_start, 32'd4);
    check_eq("t5 rx count", rx_n - b_rx, 32'd4);
    check_rx("t5 rx3", b_rx + 3, 8'h13, 1'b1);
    check_eq("t5 no extra frame", 32'(busy), 32'd0);

    // Reset during WAIT_DONE of byte 2 of 4
    take_base();
    for (int i = 0; i < 4; i++) push("t6", 8'h21 + 8'(i), i == 3);
    begin
      int n = 0;
      while (n_start - b_start < 2 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("t6 reached byte2", n_start - b_start, 32'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 rst cs_n", 32'(cs_n), 32'd1);
    check_eq("t6 rst busy", 32'(busy), 32'd0);
    check_eq("t6 rst rx_valid", 32'(rx_valid), 32'd0);
    check_eq("t6 rst tx_ready", 32'(tx_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_rx = rx_n;
    repeat (20) @(negedge clk);
    check_eq("t6 no rx after rst", rx_n - b_rx, 32'd0);
    check_eq("t6 rx_valid", 32'(rx_valid), 32'd0);
    check_eq("t6 idle", 32'(busy), 32'd0);
    single_byte("t6b");

    // Spurious done tick in IDLE
    b_rx = rx_n;
    @(negedge clk);
    force_tick = 1'b1;
    @(negedge clk);
    force_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t7 rx_valid", 32'(rx_valid), 32'd0);
    check_eq("t7 rx count", rx_n - b_rx, 32'd0);
    check_eq("t7 busy", 32'(busy), 32'd0);
    check_eq("t7 cs_n", 32'(cs_n), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
